// File: rtl/comparator_bist_if.sv
// Comparator-side bus of the BIST: operands out, one-hot magnitude response back.
// The BIST end uses the master modport, the comparator under test the slave modport.
interface comparator_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_greater;
  logic             a_equal;
  logic             a_less;

  modport master (
    output a, b,
    input  a_greater, a_equal, a_less
  );

  modport slave (
    input  a, b,
    output a_greater, a_equal, a_less
  );
endinterface

// File: rtl/comparator_bist.sv
// Exhaustive sweep BIST for a magnitude comparator: drives every (a, b) pair,
// checks the one-hot response after HOLD cycles and records errors and the first failing pair.
module comparator_bist #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  comparator_bist_if.master    cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b
);

  localparam int              IW        = 2 * WIDTH;
  localparam logic [3:0]      HOLD_LAST = 4'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx;
  logic [3:0]      hold_cnt;
  logic [2:0]      exp_resp;
  logic [2:0]      act_resp;
  logic            check_now;
  logic            last_vec;
  logic            vec_fail;
  logic            launch;

  // Operands come straight from the index flops, so they are registered and
  // return to zero automatically when the index wraps after the last vector.
  assign cmp.a = idx[IW-1:WIDTH];
  assign cmp.b = idx[WIDTH-1:0];

  assign exp_resp  = {cmp.a > cmp.b, cmp.a == cmp.b, cmp.a < cmp.b};
  assign act_resp  = {cmp.a_greater, cmp.a_equal, cmp.a_less};
  assign check_now = (state_q == RUN) && (hold_cnt == HOLD_LAST);
  assign last_vec  = (idx == {IW{1'b1}});
  assign vec_fail  = (act_resp != exp_resp);
  assign launch    = (state_q != RUN) && start;

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)               state_d = RUN;
      RUN:        if (check_now && last_vec) state_d = DONE;
      default:                             state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      hold_cnt   <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (launch) begin
      idx        <= '0;
      hold_cnt   <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (check_now) begin
      idx      <= idx + IW'(1);
      hold_cnt <= '0;
      if (vec_fail) begin
        err_count <= err_count + (IW + 1)'(1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= cmp.a;
          fail_b     <= cmp.b;
        end
      end
    end else if (state_q == RUN) begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: behavioural comparators with injectable faults, a table of
// sweeps scored through an expected-result queue, plus reset and HOLD=3 sequences.
module tb_comparator_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  int         fault1 = 0;
  logic [1:0] ph = 2'd0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  comparator_bist_if #(.WIDTH(4)) cif1 ();
  comparator_bist_if #(.WIDTH(4)) cif3 ();

  logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [8:0] err1, err3;
  logic [3:0] fa1, fb1, fa3, fb3;

  comparator_bist #(.WIDTH(4), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmp(cif1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
  );

  comparator_bist #(.WIDTH(4), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cmp(cif3.master),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
  );

  // Comparator for dut1: mode 1 = a_equal stuck at 0, mode 2 = a_greater inverted at (10,4).
  always_comb begin
    cif1.a_greater = (cif1.a > cif1.b) ^ (fault1 == 2 && cif1.a == 4'd10 && cif1.b == 4'd4);
    cif1.a_equal   = (cif1.a == cif1.b) && (fault1 != 1);
    cif1.a_less    = (cif1.a < cif1.b);
  end

  // Phase of dut3's 3-cycle hold window; the response is corrupted on phases 0 and 1 only.
  always @(posedge clk) begin
    if (start3)         ph <= 2'd0;
    else if (ph == 2'd2) ph <= 2'd0;
    else                ph <= ph + 2'd1;
  end

  always_comb begin
    cif3.a_greater = (cif3.a > cif3.b);
    cif3.a_equal   = (cif3.a == cif3.b) ^ (ph != 2'd2);
    cif3.a_less    = (cif3.a < cif3.b);
  end

  typedef struct packed {
    logic       done;
    logic       pass;
    logic [8:0] err;
    logic       fv;
    logic [3:0] fa;
    logic [3:0] fb;
  } res_t;

  typedef struct {
    int   fault;
    int   repulse;
    int   first_fail;
    res_t exp;
  } vec_t;

  res_t sb[$];
  vec_t table_v[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_result(input string tag, input res_t exp);
    check({tag, "_done"}, done1, exp.done);
    check({tag, "_pass"}, pass1, exp.pass);
    check({tag, "_err"},  err1,  exp.err);
    check({tag, "_fv"},   fv1,   exp.fv);
    check({tag, "_fail_ab"}, {fa1, fb1}, {exp.fa, exp.fb});
    check({tag, "_busy_low"}, busy1, 0);
    check({tag, "_ab_zero"}, {cif1.a, cif1.b}, 0);
  endtask

  task automatic run_sweep1(input vec_t v);
    int         n;
    logic [7:0] nv;
    res_t       exp;
    fault1 = v.fault;
    sb.push_back(v.exp);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    check("start_busy", busy1, 1);
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 2000) begin
      nv = n[7:0];
      check("vector_ab", {cif1.a, cif1.b}, nv);
      check("not_done_while_busy", done1, 0);
      if (v.first_fail >= 0 && n == v.first_fail)     check("fv_before_check", fv1, 0);
      if (v.first_fail >= 0 && n == v.first_fail + 1) check("fv_after_check", fv1, 1);
      start1 = (n == v.repulse);
      n++;
      @(negedge clk);
    end
    start1 = 1'b0;
    check("busy_cycles", n, 256);
    exp = sb.pop_front();
    check_result("sweep", exp);
  endtask

  initial begin
    int         n;
    logic [7:0] nv;

    table_v[0] = '{fault: 0, repulse: -1, first_fail: -1,
                   exp: '{done: 1, pass: 1, err: 0,  fv: 0, fa: 0,  fb: 0}};
    table_v[1] = '{fault: 1, repulse: -1, first_fail: 0,
                   exp: '{done: 1, pass: 0, err: 16, fv: 1, fa: 0,  fb: 0}};
    table_v[2] = '{fault: 2, repulse: 50, first_fail: 164,
                   exp: '{done: 1, pass: 0, err: 1,  fv: 1, fa: 10, fb: 4}};
    table_v[3] = '{fault: 0, repulse: -1, first_fail: -1,
                   exp: '{done: 1, pass: 1, err: 0,  fv: 0, fa: 0,  fb: 0}};

    #1;
    check("rst_outputs", {busy1, done1, pass1, err1, fv1, fa1, fb1, cif1.a, cif1.b}, 0);
    check("rst_outputs3", {busy3, done3, pass3, err3, fv3, fa3, fb3, cif3.a, cif3.b}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a failing sweep clears everything before the next edge.
    fault1 = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_rst_err_nonzero", (err1 != 0), 1);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {busy1, done1, pass1, err1, fv1, fa1, fb1, cif1.a, cif1.b}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (table_v[i]) run_sweep1(table_v[i]);

    // HOLD=3: each vector held three cycles, glitches outside the check cycle ignored.
    sb.push_back('{done: 1, pass: 1, err: 0, fv: 0, fa: 0, fb: 0});
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0;
    while (busy3 && n < 3000) begin
      nv = 8'(n / 3);
      check("hold3_vector_ab", {cif3.a, cif3.b}, nv);
      n++;
      @(negedge clk);
    end
    check("hold3_busy_cycles", n, 768);
    begin
      res_t exp3;
      exp3 = sb.pop_front();
      check("hold3_done", done3, exp3.done);
      check("hold3_pass", pass3, exp3.pass);
      check("hold3_err",  err3,  exp3.err);
      check("hold3_fv",   fv3,   exp3.fv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/comparator_bist.md
# comparator_bist

Built-in self-test engine for the team's `comparator_4bit` block and its wider variants. It drives every (a, b) operand pair into a magnitude comparator and samples the comparator's `a_greater` / `a_equal` / `a_less` outputs. It checks those outputs against an internally computed expected result and reports pass/fail, an error count and the first failing pair. It sits beside the comparator instance as the driving and checking end of its interface, replacing the open-loop stimulus used in simulation.

## Interface
- `WIDTH`, default 4: operand width; legal range 1..8.
- `HOLD`, default 1: clock cycles each vector is held before it is checked; legal range 1..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: pulse to begin a sweep; sampled only in IDLE or DONE.
- `a` out WIDTH: operand A driven to the comparator; registered.
- `b` out WIDTH: operand B driven to the comparator; registered.
- `a_greater` in 1: comparator response.
- `a_equal` in 1: comparator response.
- `a_less` in 1: comparator response.
- `busy` out 1: high while the sweep is running.
- `done` out 1: high in DONE; held until the next start or reset.
- `pass` out 1: valid while `done` is high; 1 when `err_count` is 0.
- `err_count` out 2*WIDTH+1: number of failing vectors; max 2^(2*WIDTH), so it never wraps.
- `fail_valid` out 1: high once the first failure has been captured.
- `fail_a` out WIDTH: operand A of the first failing vector.
- `fail_b` out WIDTH: operand B of the first failing vector.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 -> RUN.
  - On that edge: vector index = 0, hold counter = 0, `err_count` = 0, `fail_valid` = 0, `fail_a` = 0, `fail_b` = 0.
- **RUN**
  - Vector index is 2*WIDTH bits; `a` = index[2W-1:W], `b` = index[W-1:0]. B is the inner loop, A the outer.
  - Hold counter counts 0..HOLD-1 per vector.
  - The check fires on the edge where the hold counter equals HOLD-1.
- **Expected response:** {gt, eq, lt} = {a>b, a==b, a<b}, unsigned compare of the registered `a` and `b`.
- **Vector failure:** {a_greater, a_equal, a_less} differs from expected in any bit. This includes none-hot and multi-hot responses.
- **On a failing check:**
  - `err_count` increments.
  - If `fail_valid` is 0: capture current `a`/`b` into `fail_a`/`fail_b` and set `fail_valid`=1.
- **After each check:** the index increments and the hold counter returns to 0.
- **Last vector:** after the check of index 2^(2W)-1 -> DONE. On that edge `a` and `b` = 0, `busy`=0, `done`=1, and `pass` = (final `err_count` == 0). The final count includes the last vector's result.
- **`start` while in RUN:** ignored.
- **DONE**
  - Results are held.
  - `start`=1 -> RUN, with the same clearing as from IDLE (restart).
- **Reset values:** state IDLE; `a`, `b`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `fail_a`, `fail_b` all 0.
- **Reset mid-sweep:** all outputs go to reset values immediately (asynchronous). No partial results are retained.

## Timing
- Edge E0 samples `start`=1. From E0: `busy`=1 and `a`=`b`=0 (vector 0).
- Vector k is driven from edge E(k*HOLD) and checked at edge E((k+1)*HOLD).
- The comparator path is combinational from the registered `a`/`b`. It must settle within HOLD cycles; with HOLD=1 that is within one clock period.
- `done` rises at E(2^(2W)*HOLD), i.e. edge 256 for WIDTH=4 and HOLD=1.
- `busy` falls on the same edge that `done` rises; `busy` and `done` are never both 1.
- `err_count` and the `fail_*` outputs update on the check edge and are visible the cycle after.

## Test plan
- **Correct comparator (WIDTH=4, HOLD=1):** pulse `start` -> `busy` for exactly 256 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- **`a_equal` stuck at 0:** full sweep -> `err_count`=16, `fail_a`=0, `fail_b`=0, `pass`=0.
- **Single-pair fault:** `a_greater` inverted only for a=10, b=4 -> `err_count`=1, `fail_a`=10, `fail_b`=4, `pass`=0.
- **HOLD=3:** each (a, b) is stable for 3 cycles; `done` rises 768 cycles after the start edge. A fault injected only in the first 2 cycles of a vector -> `err_count`=0.
- **`start` re-pulsed at cycle 50 of a sweep:** ignored; `done` still at cycle 256. Then `start` in DONE with a fault removed -> counters cleared and `pass`=1 after the second sweep.
- **`rst` at cycle 100:** all outputs read 0 immediately (before the next edge); the next `start` runs a full 256-vector sweep from a=0, b=0.
